// File: rtl/benes_route_sequencer.sv
`default_nettype none
// ============================================================================
// benes_route_sequencer : route-table driven select sequencer for a Benes
// fabric (load, settle, stream launch beats, drain to done pulse).
// Revision: 1.0
// ============================================================================
module benes_route_sequencer #(
    parameter int STAGE_NUM  = 9,
    parameter int SWITCH_NUM = 16,
    parameter int CFG_DEPTH  = 8,
    parameter int PIPE_LAT   = 13,
    parameter int TAG_WIDTH  = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int SEL_W     = STAGE_NUM * SWITCH_NUM,
    localparam int IDX_W     = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CFG_WE,
    input  logic [IDX_W-1:0]     CFG_ADDR,
    input  logic [SEL_W-1:0]     CFG_MODULE_SEL,
    input  logic [SEL_W-1:0]     CFG_SLOT_SEL,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [IDX_W-1:0]     REQ_CFG_IDX,
    input  logic [TAG_WIDTH-1:0] REQ_TAG,
    input  logic [CNT_WIDTH-1:0] REQ_COUNT,
    output logic [SEL_W-1:0]     O_MODULE_SELECT,
    output logic [SEL_W-1:0]     O_SLOT_SELECT,
    output logic                 O_LAUNCH,
    output logic                 O_DONE_VALID,
    output logic [TAG_WIDTH-1:0] O_DONE_TAG,
    output logic                 O_BUSY
);

    localparam int BW  = CNT_WIDTH + 1;
    localparam int DRW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRW-1:0]   DRAIN_INIT = DRW'(PIPE_LAT - 1);
    localparam logic [IDX_W:0]   DEPTH_C    = (IDX_W + 1)'(CFG_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [BW-1:0]        beat_cnt, beat_nx;
    logic [DRW-1:0]       drain_cnt, drain_nx;
    logic                 settle_q, settle_nx;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [SEL_W-1:0]     tbl_mod  [CFG_DEPTH];
    logic [SEL_W-1:0]     tbl_slot [CFG_DEPTH];
    logic [SEL_W-1:0]     rd_mod, rd_slot;
    logic                 accept;

    assign accept    = REQ_VALID && (state == IDLE);
    assign REQ_READY = (state == IDLE);
    assign O_BUSY    = (state != IDLE);
    assign O_LAUNCH  = (state == STREAM);
    assign O_DONE_VALID = (state == DRAIN) && (drain_cnt == '0);

    // Indices beyond the populated depth read back as a neutral all-zero route.
    always_comb begin
        rd_mod  = '0;
        rd_slot = '0;
        if ({1'b0, REQ_CFG_IDX} < DEPTH_C) begin
            rd_mod  = tbl_mod[REQ_CFG_IDX];
            rd_slot = tbl_slot[REQ_CFG_IDX];
        end
    end

    always_comb begin
        state_nx  = state;
        beat_nx   = beat_cnt;
        drain_nx  = drain_cnt;
        settle_nx = settle_q;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    state_nx = LOAD;
                    beat_nx  = (REQ_COUNT == '0) ? BW'(1) : {1'b0, REQ_COUNT};
                end
            end
            LOAD: begin
                state_nx  = SETTLE;
                settle_nx = 1'b0;
            end
            SETTLE: begin
                settle_nx = 1'b1;
                if (settle_q) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                beat_nx = beat_cnt - BW'(1);
                if (beat_cnt == BW'(1)) begin
                    state_nx = DRAIN;
                    drain_nx = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    drain_nx = drain_cnt - DRW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            settle_q  <= 1'b0;
        end else begin
            state     <= state_nx;
            beat_cnt  <= beat_nx;
            drain_cnt <= drain_nx;
            settle_q  <= settle_nx;
        end
    end

    // Selects are captured from the table at acceptance, so later table writes
    // (including one on the accepting edge) never disturb an active route.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_q           <= '0;
            O_MODULE_SELECT <= '0;
            O_SLOT_SELECT   <= '0;
            O_DONE_TAG      <= '0;
        end else begin
            if (accept) begin
                tag_q           <= REQ_TAG;
                O_MODULE_SELECT <= rd_mod;
                O_SLOT_SELECT   <= rd_slot;
            end
            if ((state_nx == DRAIN) && (drain_nx == '0)) begin
                O_DONE_TAG <= tag_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                tbl_mod[i]  <= '0;
                tbl_slot[i] <= '0;
            end
        end else if (CFG_WE && ({1'b0, CFG_ADDR} < DEPTH_C)) begin
            tbl_mod[CFG_ADDR]  <= CFG_MODULE_SEL;
            tbl_slot[CFG_ADDR] <= CFG_SLOT_SEL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_benes_route_sequencer.sv
`default_nettype none
// ============================================================================
// tb_benes_route_sequencer : directed self-checking bench for the sequencer.
// Revision: 1.0
// ============================================================================
module tb_benes_route_sequencer;

    localparam int SEL_W = 144;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              CFG_WE = 1'b0;
    logic [2:0]        CFG_ADDR = '0;
    logic [SEL_W-1:0]  CFG_MODULE_SEL = '0;
    logic [SEL_W-1:0]  CFG_SLOT_SEL = '0;
    logic              REQ_VALID = 1'b0;
    logic              REQ_READY;
    logic [2:0]        REQ_CFG_IDX = '0;
    logic [3:0]        REQ_TAG = '0;
    logic [7:0]        REQ_COUNT = '0;
    logic [SEL_W-1:0]  O_MODULE_SELECT;
    logic [SEL_W-1:0]  O_SLOT_SELECT;
    logic              O_LAUNCH;
    logic              O_DONE_VALID;
    logic [3:0]        O_DONE_TAG;
    logic              O_BUSY;

    int checks = 0;
    int passes = 0;

    benes_route_sequencer dut (
        .CLK(CLK), .RST_N(RST_N),
        .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
        .CFG_MODULE_SEL(CFG_MODULE_SEL), .CFG_SLOT_SEL(CFG_SLOT_SEL),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_CFG_IDX(REQ_CFG_IDX), .REQ_TAG(REQ_TAG), .REQ_COUNT(REQ_COUNT),
        .O_MODULE_SELECT(O_MODULE_SELECT), .O_SLOT_SELECT(O_SLOT_SELECT),
        .O_LAUNCH(O_LAUNCH), .O_DONE_VALID(O_DONE_VALID),
        .O_DONE_TAG(O_DONE_TAG), .O_BUSY(O_BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [SEL_W-1:0] ms,
                             input logic [SEL_W-1:0] ss);
        CFG_WE = 1'b1; CFG_ADDR = addr; CFG_MODULE_SEL = ms; CFG_SLOT_SEL = ss;
        step();
        CFG_WE = 1'b0;
    endtask

    // Full request: launch offset, beat count, done latency, tag and select hold.
    task automatic run_req(input string nm, input logic [2:0] idx, input logic [3:0] tag,
                           input logic [7:0] cnt, input logic [SEL_W-1:0] em,
                           input logic [SEL_W-1:0] es, input int exp_beats);
        int beats = 0;
        int gap = 1;
        int bad_hold = 0;
        REQ_VALID = 1'b1; REQ_CFG_IDX = idx; REQ_TAG = tag; REQ_COUNT = cnt;
        checks++;
        if (REQ_READY !== 1'b1) $display("FAIL %s ready_idle got %b want 1", nm, REQ_READY);
        else passes++;
        step();
        REQ_VALID = 1'b0;
        checks++;
        if (REQ_READY !== 1'b0 || O_BUSY !== 1'b1 || O_LAUNCH !== 1'b0 ||
            O_MODULE_SELECT !== em || O_SLOT_SELECT !== es)
            $display("FAIL %s load rdy=%b busy=%b launch=%b mod=%h slot=%h want 0 1 0 %h %h",
                     nm, REQ_READY, O_BUSY, O_LAUNCH, O_MODULE_SELECT, O_SLOT_SELECT, em, es);
        else passes++;
        step(); step();
        checks++;
        if (O_LAUNCH !== 1'b0) $display("FAIL %s settle_launch got %b want 0", nm, O_LAUNCH);
        else passes++;
        step();
        while (O_LAUNCH === 1'b1 && beats < 300) begin
            beats++;
            if (REQ_READY !== 1'b0 || O_MODULE_SELECT !== em || O_SLOT_SELECT !== es) bad_hold++;
            step();
        end
        checks++;
        if (beats != exp_beats) $display("FAIL %s beats got %0d want %0d", nm, beats, exp_beats);
        else passes++;
        while (O_DONE_VALID !== 1'b1 && gap < 40) begin
            if (O_BUSY !== 1'b1 || O_MODULE_SELECT !== em) bad_hold++;
            step();
            gap++;
        end
        checks++;
        if (gap != 13 || O_DONE_TAG !== tag)
            $display("FAIL %s done_latency got %0d tag %h want 13 tag %h", nm, gap, O_DONE_TAG, tag);
        else passes++;
        checks++;
        if (bad_hold != 0) $display("FAIL %s select_hold got %0d bad cycles want 0", nm, bad_hold);
        else passes++;
        step();
        checks++;
        if (O_DONE_VALID !== 1'b0 || O_BUSY !== 1'b0 || REQ_READY !== 1'b1 ||
            O_DONE_TAG !== tag || O_MODULE_SELECT !== em)
            $display("FAIL %s idle_after done=%b busy=%b rdy=%b tag=%h want 0 0 1 %h",
                     nm, O_DONE_VALID, O_BUSY, REQ_READY, O_DONE_TAG, tag);
        else passes++;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        step(); step();
        checks++;
        if (REQ_READY !== 1'b1 || O_LAUNCH !== 1'b0 || O_DONE_VALID !== 1'b0 ||
            O_BUSY !== 1'b0 || O_DONE_TAG !== 4'h0 || O_MODULE_SELECT !== '0 ||
            O_SLOT_SELECT !== '0)
            $display("FAIL reset_state rdy=%b launch=%b done=%b busy=%b tag=%h want 1 0 0 0 0",
                     REQ_READY, O_LAUNCH, O_DONE_VALID, O_BUSY, O_DONE_TAG);
        else passes++;
        RST_N = 1'b1;
    endtask

    task automatic test_basic();
        // Request right after reset release must be accepted on the first edge.
        run_req("first_after_reset", 3'd0, 4'h7, 8'd2, '0, '0, 2);
        cfg_write(3'd3, '1, {9{16'hA5C3}});
        run_req("basic", 3'd3, 4'h5, 8'd4, '1, {9{16'hA5C3}}, 4);
    endtask

    task automatic test_count_zero();
        cfg_write(3'd1, {9{16'h1234}}, {9{16'h8001}});
        run_req("count_zero", 3'd1, 4'h9, 8'd0, {9{16'h1234}}, {9{16'h8001}}, 1);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int rdy_bad = 0;
        int gap = 0;
        cfg_write(3'd4, {9{16'h0F0F}}, {9{16'hF0F0}});
        REQ_VALID = 1'b1; REQ_CFG_IDX = 3'd1; REQ_TAG = 4'h2; REQ_COUNT = 8'd1;
        step();
        REQ_CFG_IDX = 3'd4; REQ_TAG = 4'hB;
        while (REQ_READY !== 1'b1 && cyc < 40) begin
            if (O_BUSY !== 1'b1) rdy_bad++;
            step();
            cyc++;
        end
        checks++;
        if (cyc != 17 || rdy_bad != 0)
            $display("FAIL b2b_ready_low got %0d cycles (%0d bad) want 17", cyc, rdy_bad);
        else passes++;
        step();
        REQ_VALID = 1'b0;
        checks++;
        if (O_BUSY !== 1'b1 || O_MODULE_SELECT !== {9{16'h0F0F}} || O_SLOT_SELECT !== {9{16'hF0F0}})
            $display("FAIL b2b_second_load busy=%b mod=%h want 1 %h", O_BUSY, O_MODULE_SELECT,
                     {9{16'h0F0F}});
        else passes++;
        while (O_DONE_VALID !== 1'b1 && gap < 60) begin
            step();
            gap++;
        end
        checks++;
        if (gap != 16 || O_DONE_TAG !== 4'hB)
            $display("FAIL b2b_second_done got %0d tag %h want 16 tag b", gap, O_DONE_TAG);
        else passes++;
        step();
    endtask

    task automatic test_cfg_during_stream();
        int guard = 0;
        // Write on the accepting edge to the same entry: old contents apply.
        REQ_VALID = 1'b1; REQ_CFG_IDX = 3'd3; REQ_TAG = 4'h6; REQ_COUNT = 8'd4;
        CFG_WE = 1'b1; CFG_ADDR = 3'd3;
        CFG_MODULE_SEL = {9{16'h5555}}; CFG_SLOT_SEL = {9{16'h3333}};
        step();
        REQ_VALID = 1'b0; CFG_WE = 1'b0;
        checks++;
        if (O_MODULE_SELECT !== '1 || O_SLOT_SELECT !== {9{16'hA5C3}})
            $display("FAIL same_cycle_nobypass mod=%h slot=%h want all-ones %h",
                     O_MODULE_SELECT, O_SLOT_SELECT, {9{16'hA5C3}});
        else passes++;
        step(); step(); step();
        CFG_WE = 1'b1; CFG_ADDR = 3'd3;
        CFG_MODULE_SEL = {9{16'hC0DE}}; CFG_SLOT_SEL = {9{16'hBEEF}};
        step();
        CFG_WE = 1'b0;
        checks++;
        if (O_LAUNCH !== 1'b1 || O_MODULE_SELECT !== '1 || O_SLOT_SELECT !== {9{16'hA5C3}})
            $display("FAIL stream_write_isolated launch=%b mod=%h want 1 all-ones",
                     O_LAUNCH, O_MODULE_SELECT);
        else passes++;
        while (REQ_READY !== 1'b1 && guard < 40) begin
            step();
            guard++;
        end
        run_req("cfg_new_value", 3'd3, 4'hA, 8'd3, {9{16'hC0DE}}, {9{16'hBEEF}}, 3);
    endtask

    task automatic test_reset_mid_stream();
        int done_seen = 0;
        REQ_VALID = 1'b1; REQ_CFG_IDX = 3'd4; REQ_TAG = 4'hD; REQ_COUNT = 8'd5;
        step();
        REQ_VALID = 1'b0;
        step(); step(); step(); step();
        RST_N = 1'b0;
        #1;
        checks++;
        if (O_LAUNCH !== 1'b0 || O_BUSY !== 1'b0 || REQ_READY !== 1'b1 ||
            O_MODULE_SELECT !== '0 || O_SLOT_SELECT !== '0 || O_DONE_TAG !== 4'h0)
            $display("FAIL async_reset launch=%b busy=%b rdy=%b tag=%h want 0 0 1 0",
                     O_LAUNCH, O_BUSY, REQ_READY, O_DONE_TAG);
        else passes++;
        step(); step();
        RST_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (O_DONE_VALID !== 1'b0 || O_BUSY !== 1'b0) done_seen++;
            step();
        end
        checks++;
        if (done_seen != 0) $display("FAIL reset_no_done got %0d active cycles want 0", done_seen);
        else passes++;
        run_req("table_cleared", 3'd3, 4'h1, 8'd1, '0, '0, 1);
    endtask

    task automatic test_count_255();
        cfg_write(3'd2, {9{16'h7E81}}, {9{16'h0102}});
        run_req("count_255", 3'd2, 4'hC, 8'd255, {9{16'h7E81}}, {9{16'h0102}}, 255);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_count_zero();
        test_back_to_back();
        test_cfg_during_stream();
        test_reset_mid_stream();
        test_count_255();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/benes_route_sequencer.md
BENES_ROUTE_SEQUENCER -- requirements
Module: benes_route_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- STAGE_NUM, 9, Benes stages.
- SWITCH_NUM, 16, 2x2 switches per stage.
- CFG_DEPTH, 8, route-table entries.
- PIPE_LAT, 13, cycles from launch beat to data at fabric output.
- TAG_WIDTH, 4, request tag width.
- CNT_WIDTH, 8, beat-count width.
REQ-002 Reset SHALL be RST_N, asynchronous, active-low; clock SHALL be CLK.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- CLK  in  1  clock.
- RST_N  in  1  async active-low reset.
- CFG_WE  in  1  route-table write strobe.
- CFG_ADDR  in  clog2(CFG_DEPTH)  table entry to write.
- CFG_MODULE_SEL  in  STAGE_NUM*SWITCH_NUM  RAM-to-module switch settings.
- CFG_SLOT_SEL  in  STAGE_NUM*SWITCH_NUM  module-to-RAM switch settings.
- REQ_VALID  in  1  route request.
- REQ_READY  out  1  request accepted when VALID and READY are both high.
- REQ_CFG_IDX  in  clog2(CFG_DEPTH)  table entry to apply.
- REQ_TAG  in  TAG_WIDTH  request identifier.
- REQ_COUNT  in  CNT_WIDTH  data beats to launch.
- O_MODULE_SELECT  out  STAGE_NUM*SWITCH_NUM  to fabric I_MODULE_SELECT.
- O_SLOT_SELECT  out  STAGE_NUM*SWITCH_NUM  to fabric I_SLOT_SELECT.
- O_LAUNCH  out  1  data beat may enter fabric this cycle.
- O_DONE_VALID  out  1  one-cycle pulse: last beat at fabric output.
- O_DONE_TAG  out  TAG_WIDTH  tag of completed request.
- O_BUSY  out  1  high in any state other than IDLE.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, SETTLE, STREAM, DRAIN.
REQ-005 REQ_READY SHALL be high only in IDLE.
REQ-006 On acceptance: latch tag, count and table entry REQ_CFG_IDX into the select output registers; next state LOAD.
REQ-007 LOAD SHALL last 1 cycle and drive the new selects; next state SETTLE.
REQ-008 SETTLE SHALL last 2 cycles (fabric select-register and input-register alignment); next state STREAM.
REQ-009 STREAM: O_LAUNCH high for exactly N consecutive cycles, N = REQ_COUNT; REQ_COUNT = 0 SHALL be treated as N = 1.
REQ-010 After the last launch beat, state SHALL be DRAIN. A down-counter loaded with PIPE_LAT-1 SHALL decrement each cycle.
REQ-011 If the last launch is at cycle t, O_DONE_VALID SHALL be high only at cycle t+PIPE_LAT, with O_DONE_TAG equal to the latched tag; IDLE SHALL be entered at t+PIPE_LAT+1.
REQ-012 O_MODULE_SELECT and O_SLOT_SELECT SHALL hold constant from LOAD through DRAIN, and in IDLE SHALL keep the last applied value.
REQ-013 The route table SHALL be CFG_DEPTH entries of registers, written on CFG_WE in any state.
REQ-014 A write to the entry in use SHALL NOT alter the latched outputs of the active request.
REQ-015 A CFG_WE in the same cycle as request acceptance to the same index SHALL NOT bypass: the old table contents are applied.
REQ-016 O_DONE_TAG SHALL hold its last value between pulses.
REQ-017 A table read for an index at or above CFG_DEPTH (non-power-of-2 depth) SHALL return all-zero selects.
REQ-018 Widths: the beat counter SHALL be CNT_WIDTH+1 bits, with no wrap for N = 2^CNT_WIDTH-1.

Reset
REQ-019 Reset SHALL force: state IDLE; REQ_READY=1; O_LAUNCH=0; O_DONE_VALID=0; O_BUSY=0; O_DONE_TAG=0; selects=0; all table entries=0; counters=0.
REQ-020 Reset asserted mid-STREAM or mid-DRAIN SHALL drop O_LAUNCH and O_BUSY immediately (asynchronously), and SHALL produce no O_DONE_VALID pulse.
REQ-021 After reset release, the first REQ_VALID SHALL be accepted on the first rising edge.

Verification
REQ-022 Write entry 3 (module sel = all-ones), then request idx 3, tag 5, count 4 -> selects all-ones from the LOAD cycle; O_LAUNCH high 4 cycles starting 3 cycles after acceptance; O_DONE_VALID with tag 5 exactly 13 cycles after the 4th launch.
REQ-023 Request with count 0 -> exactly 1 launch beat, then done 13 cycles later.
REQ-024 Two back-to-back REQ_VALID -> second accepted only the cycle after IDLE is re-entered; REQ_READY low throughout the first request.
REQ-025 CFG_WE to the active entry during STREAM -> outputs unchanged; the next request to that entry applies the new value.
REQ-026 RST_N low at the 2nd STREAM beat -> all outputs at reset values immediately; no done pulse; table cleared.
REQ-027 Count 255 -> exactly 255 launch beats, no counter wrap, done tag correct.
